burst_line_adaptor: RTL and testbench

Parametrised bridge between the last-level cache and physical memory. Splits a cache-line write into a burst of memory beats and assembles a burst of read beats into a full line. Width and beat count are generic, and memory may stall between beats. An optional posted-write mode releases the cache before the write-back drains. Sits between the LLC miss/write-back port and the memory controller port.

---
 rtl/burst_line_adaptor.sv | 138 +++++++++++++
 tb/tb_burst_line_adaptor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adaptor.sv
// LLC <-> memory burst bridge: splits write-back lines into beats and assembles read beats into lines.
// Optional posted-write mode under `ADAPTOR_POSTED_WRITE_EN` (undefined by default: writes finish through DONE).
module burst_line_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [LINE_W-1:0] line_i,
   output logic [LINE_W-1:0] line_o,
   input  logic [ADDR_W-1:0] address_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
);

   // state | meaning
   // IDLE  | waiting for an LLC request; write wins over read
   // RD    | collecting read beats from memory
   // WR    | presenting write beats to memory
   // DONE  | one-cycle completion pulse to the LLC

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   beat_cnt;
   logic [LINE_W-1:0]  shift_buf;
   logic               accept_wr;
   logic               accept_rd;
   logic               beat;
   logic               last_beat;

   assign accept_wr = (state == IDLE) && write_i;
   assign accept_rd = (state == IDLE) && read_i && !write_i;
   assign beat      = resp_i && ((state == RD) || (state == WR));
   assign last_beat = beat && (beat_cnt == LAST_BEAT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (write_i) begin
               state_nxt = WR;
            end else if (read_i) begin
               state_nxt = RD;
            end
         end
         RD: begin
            if (last_beat) begin
               state_nxt = DONE;
            end
         end
         WR: begin
            if (last_beat) begin
`ifdef ADAPTOR_POSTED_WRITE_EN
               state_nxt = IDLE;
`else
               state_nxt = DONE;
`endif
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ADAPTOR_POSTED_WRITE_EN
   // The LLC is released the cycle after a write is accepted; the drain continues in WR.
   logic posted_resp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         posted_resp <= 1'b0;
      end else begin
         posted_resp <= accept_wr;
      end
   end

   always_comb begin
      read_o  = (state == RD);
      write_o = (state == WR);
      resp_o  = (state == DONE) || posted_resp;
   end
`else
   always_comb begin
      read_o  = (state == RD);
      write_o = (state == WR);
      resp_o  = (state == DONE);
   end
`endif

   // One buffer serves both directions: writes shift out at the bottom, reads shift in at the top.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         address_o <= '0;
         beat_cnt  <= '0;
         shift_buf <= '0;
         line_o    <= '0;
      end else if (accept_wr || accept_rd) begin
         address_o <= address_i & ALIGN_MASK;
         beat_cnt  <= '0;
         if (accept_wr) begin
            shift_buf <= line_i;
         end
      end else if (beat) begin
         beat_cnt  <= beat_cnt + 1'b1;
         shift_buf <= {((state == RD) ? burst_i : {BURST_W{1'b0}}), shift_buf[LINE_W-1:BURST_W]};
         if ((state == RD) && (beat_cnt == LAST_BEAT)) begin
            line_o <= {burst_i, shift_buf[LINE_W-1:BURST_W]};
         end
      end
   end

   assign burst_o = shift_buf[BURST_W-1:0];

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Self-checking bench for burst_line_adaptor: vector table of line transfers with scoreboard queues,
// plus hand sequences for request priority, mid-burst reset and posted writes.
module tb_burst_line_adaptor;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;
   localparam int BEATS   = LINE_W / BURST_W;
`ifdef ADAPTOR_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic               clk;
   logic               reset_n;
   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   logic [ADDR_W-1:0]  address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   burst_line_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] exp_addr;
      logic [LINE_W-1:0] data;
      int                maxgap;
   } vec_t;

   vec_t vecs[7];

   int n_err = 0;
   int n_chk = 0;

   logic [ADDR_W-1:0]  addr_q[$];
   logic [LINE_W-1:0]  line_q[$];
   logic [BURST_W-1:0] beat_q[$];
   logic [LINE_W-1:0]  last_line;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One full LLC transaction with random resp_i gaps (0..maxgap) before each beat.
   task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] exp_addr,
                          input logic [LINE_W-1:0] data, input int maxgap);
      bit first;
      int g;
      address_i = addr;
      if (wr) begin
         line_i  = data;
         write_i = 1'b1;
         for (int k = 0; k < BEATS; k++) beat_q.push_back(data[k*BURST_W +: BURST_W]);
      end else begin
         read_i = 1'b1;
         line_q.push_back(data);
      end
      addr_q.push_back(exp_addr);
      @(negedge clk);
      chk("req_rise", 256'({read_o, write_o}), wr ? 256'(2'b01) : 256'(2'b10));
      chk("address_o", 256'(address_o), 256'(addr_q.pop_front()));
      chk("resp_at_t1", 256'(resp_o), 256'(POSTED && wr));
      if (POSTED && wr) write_i = 1'b0;
      first = 1'b1;
      for (int k = 0; k < BEATS; k++) begin
         g = $urandom_range(0, maxgap);
         repeat (g) begin
            resp_i = 1'b0;
            if (!first) begin
               chk("resp_low_mid", 256'(resp_o), 256'(0));
               chk("req_hold", 256'({read_o, write_o}), wr ? 256'(2'b01) : 256'(2'b10));
            end
            if (wr) chk("burst_hold_gap", 256'(burst_o), 256'(beat_q[0]));
            first = 1'b0;
            @(negedge clk);
         end
         resp_i = 1'b1;
         if (!first) begin
            chk("resp_low_mid", 256'(resp_o), 256'(0));
            chk("req_hold", 256'({read_o, write_o}), wr ? 256'(2'b01) : 256'(2'b10));
         end
         if (wr) chk("burst_o", 256'(burst_o), 256'(beat_q.pop_front()));
         else burst_i = data[k*BURST_W +: BURST_W];
         first = 1'b0;
         @(negedge clk);
      end
      resp_i  = 1'b0;
      burst_i = '0;
      chk("req_fall", 256'({read_o, write_o}), 256'(2'b00));
      chk("resp_final", 256'(resp_o), 256'(!(POSTED && wr)));
      if (!wr) last_line = line_q.pop_front();
      chk("line_o", line_o, last_line);
      if (wr) write_i = 1'b0;
      else read_i = 1'b0;
      @(negedge clk);
      chk("resp_single", 256'(resp_o), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 32'h1234_5678, 32'h1234_5660,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0};
      vecs[1] = '{1'b1, 32'h1234_5678, 32'h1234_5660,
                  {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002, 64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000}, 0};
      vecs[2] = '{1'b0, 32'h0000_0040, 32'h0000_0040,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 3};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0}, 2};
      vecs[4] = '{1'b0, 32'h0000_001F, 32'h0000_0000,
                  {64'hCAFE_0004_CAFE_0004, 64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002, 64'hCAFE_0001_CAFE_0001}, 1};
      vecs[5] = '{1'b1, 32'h8000_0020, 32'h8000_0020,
                  {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h7777_8888_9999_AAAA}, 3};
      vecs[6] = '{1'b0, 32'hABCD_EF00, 32'hABCD_EF00,
                  {64'h1357_9BDF_2468_ACE0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0000, 64'hBEEF_BEEF_BEEF_BEEF}, 0};

      reset_n   = 1'b0;
      line_i    = '0;
      address_i = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      burst_i   = '0;
      resp_i    = 1'b0;
      last_line = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", 256'({read_o, write_o, resp_o}), 256'(3'b000));
      chk("rst_address_o", 256'(address_o), 256'(0));
      chk("rst_burst_o", 256'(burst_o), 256'(0));
      chk("rst_line_o", line_o, 256'(0));
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].exp_addr, vecs[i].data, vecs[i].maxgap);
      end

`ifndef ADAPTOR_POSTED_WRITE_EN
      // Both requests high: write-back goes first, the held read follows.
      read_i = 1'b1;
      run_txn(1'b1, 32'h0000_3000, 32'h0000_3000,
              {64'hB3B3_B3B3_0000_0003, 64'hB2B2_B2B2_0000_0002, 64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000}, 1);
      run_txn(1'b0, 32'h0000_3004, 32'h0000_3000,
              {64'h5555_0004_0000_0000, 64'h5555_0003_0000_0000, 64'h5555_0002_0000_0000, 64'h5555_0001_0000_0000}, 2);
`endif

      // Reset after beat 2 of a read, then a clean read.
      address_i = 32'h0000_5000;
      read_i    = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         resp_i  = 1'b1;
         burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
         @(negedge clk);
      end
      resp_i  = 1'b0;
      read_i  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_req", 256'({read_o, write_o, resp_o}), 256'(3'b000));
      chk("mid_rst_address_o", 256'(address_o), 256'(0));
      chk("mid_rst_burst_o", 256'(burst_o), 256'(0));
      chk("mid_rst_line_o", line_o, 256'(0));
      last_line = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_txn(1'b0, 32'h0000_6010, 32'h0000_6000,
              {64'h6666_0004_6666_0004, 64'h6666_0003_6666_0003, 64'h6666_0002_6666_0002, 64'h6666_0001_6666_0001}, 2);

`ifdef ADAPTOR_POSTED_WRITE_EN
      begin
         logic [LINE_W-1:0] wline;
         logic [LINE_W-1:0] rline;
         wline = {64'h9003_9003_9003_9003, 64'h9002_9002_9002_9002, 64'h9001_9001_9001_9001, 64'h9000_9000_9000_9000};
         rline = {64'h7004_0000_7004_0000, 64'h7003_0000_7003_0000, 64'h7002_0000_7002_0000, 64'h7001_0000_7001_0000};
         line_i    = wline;
         address_i = 32'h0000_1040;
         write_i   = 1'b1;
         @(negedge clk);
         chk("post_resp", 256'(resp_o), 256'(1));
         chk("post_write_o", 256'({read_o, write_o}), 256'(2'b01));
         write_i   = 1'b0;
         line_i    = '1;
         address_i = 32'h2000_0013;
         for (int k = 0; k < BEATS; k++) begin
            if (k == 1) read_i = 1'b1;
            if (k > 0) chk("post_drain_req", 256'({read_o, write_o, resp_o}), 256'(3'b010));
            chk("post_burst_o", 256'(burst_o), 256'(wline[k*BURST_W +: BURST_W]));
            resp_i = 1'b1;
            @(negedge clk);
         end
         resp_i = 1'b0;
         chk("post_drained", 256'({read_o, write_o, resp_o}), 256'(3'b000));
         chk("post_addr_stable", 256'(address_o), 256'(32'h0000_1040));
         @(negedge clk);
         chk("post_read_after", 256'({read_o, write_o}), 256'(2'b10));
         chk("post_read_addr", 256'(address_o), 256'(32'h2000_0000));
         for (int k = 0; k < BEATS; k++) begin
            resp_i  = 1'b1;
            burst_i = rline[k*BURST_W +: BURST_W];
            @(negedge clk);
         end
         resp_i = 1'b0;
         read_i = 1'b0;
         chk("post_read_resp", 256'(resp_o), 256'(1));
         chk("post_read_line", line_o, rline);
         @(negedge clk);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
